// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM port arbiter and its tag FIFO.
package sdram_pkg;

   // Address width of the byte-wide SDRAM controller command interface.
   localparam int SDRAM_ADDR_DEPTH = 25;

   // Identifies which requesting port issued a command.
   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_id_t;

   // One controller command as held in the arbiter's command register.
   typedef struct packed {
      logic                        is_wr;
      logic [SDRAM_ADDR_DEPTH-1:0] addr;
      logic [7:0]                  wdata;
   } sdram_cmd_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Signal bundle between the two requesting ports, the arbiter and the SDRAM
// controller. The slave modport is the arbiter's view; the master modport is
// the view of everything around it (both clients plus the controller).
interface sdram_port_arbiter_if
   import sdram_pkg::*;
#(
   parameter int ADDR_DEPTH = SDRAM_ADDR_DEPTH
);

   // Port A (high-bandwidth client)
   logic [ADDR_DEPTH-1:0] pa_addr;
   logic [7:0]            pa_wdata;
   logic                  pa_wr;
   logic                  pa_rd;
   logic                  pa_ack;
   logic [7:0]            pa_rdata;
   logic                  pa_rval;

   // Port B (general client)
   logic [ADDR_DEPTH-1:0] pb_addr;
   logic [7:0]            pb_wdata;
   logic                  pb_wr;
   logic                  pb_rd;
   logic                  pb_ack;
   logic [7:0]            pb_rdata;
   logic                  pb_rval;

   // Controller command/response side
   logic [ADDR_DEPTH-1:0] addr_in;
   logic [7:0]            data_wr;
   logic                  wr;
   logic                  rd;
   logic                  rdy;
   logic                  val;
   logic [7:0]            data_rd;
   logic                  err_val;

   modport slave (
      input  pa_addr, pa_wdata, pa_wr, pa_rd,
      output pa_ack, pa_rdata, pa_rval,
      input  pb_addr, pb_wdata, pb_wr, pb_rd,
      output pb_ack, pb_rdata, pb_rval,
      output addr_in, data_wr, wr, rd, err_val,
      input  rdy, val, data_rd
   );

   modport master (
      output pa_addr, pa_wdata, pa_wr, pa_rd,
      input  pa_ack, pa_rdata, pa_rval,
      output pb_addr, pb_wdata, pb_wr, pb_rd,
      input  pb_ack, pb_rdata, pb_rval,
      input  addr_in, data_wr, wr, rd, err_val,
      output rdy, val, data_rd
   );

endinterface

// File: rtl/sdram_tag_fifo.sv
// Synchronous FIFO of port ids. Records which port issued each outstanding
// read so controller responses can be routed back in issue order.
module sdram_tag_fifo
   import sdram_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  port_id_t         push_id,
   input  logic             pop,
   output port_id_t         head_id,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   port_id_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap at DEPTH explicitly so DEPTH=1 also works.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head_id = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Tag storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; count/pointers define which
      // entries are meaningful, so flushing them is enough.
      if (do_push) mem[wr_ptr] <= push_id;
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the byte-wide SDRAM controller. Grants one of
// port A / port B per cycle into a one-entry command register and routes each
// read response back to the port that issued it, in order.
module sdram_port_arbiter
   import sdram_pkg::*;
#(
   parameter  int ADDR_DEPTH         = SDRAM_ADDR_DEPTH,
   parameter  int MAX_RD_OUTSTANDING = 4,
   parameter  bit FIXED_PRIORITY     = 1'b0,
   localparam int CNT_W              = $clog2(MAX_RD_OUTSTANDING) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   sdram_port_arbiter_if.slave  bus
);

   // Command register feeding the controller.
   logic       cmd_valid;
   sdram_cmd_t cmd_q;
   port_id_t   last_grant;

   // Request decode and arbitration.
   sdram_cmd_t a_cmd;
   sdram_cmd_t b_cmd;
   sdram_cmd_t win_cmd;
   port_id_t   win_id;
   logic       can_cap;
   logic       a_elig;
   logic       b_elig;
   logic       grant_a;
   logic       grant_b;
   logic       capture;

   // Read-tag tracking.
   logic             tag_push;
   logic             tag_pop;
   port_id_t         head_id;
   logic             tag_full;
   logic             tag_empty;
   logic [CNT_W-1:0] rd_count;

   // Read-return registers.
   logic       pa_rval_q;
   logic       pb_rval_q;
   logic [7:0] pa_rdata_q;
   logic [7:0] pb_rdata_q;
   logic       err_q;

   sdram_tag_fifo #(
      .DEPTH (MAX_RD_OUTSTANDING)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (tag_push),
      .push_id (win_id),
      .pop     (tag_pop),
      .head_id (head_id),
      .full    (tag_full),
      .empty   (tag_empty),
      .count   (rd_count)
   );

   // Decode each port's request and decide whether it may be captured now.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      a_cmd   = '0;
      b_cmd   = '0;
      a_cmd.is_wr = bus.pa_wr;  // wr wins when a port raises both wr and rd
      a_cmd.addr  = bus.pa_addr;
      a_cmd.wdata = bus.pa_wdata;
      b_cmd.is_wr = bus.pb_wr;
      b_cmd.addr  = bus.pb_addr;
      b_cmd.wdata = bus.pb_wdata;
      // Register can take a new command if empty or its current one issues now.
      can_cap = !cmd_valid || bus.rdy;
      // Reads also need a free tag slot; a pop this cycle does not count.
      a_elig  = !rst && (bus.pa_wr || bus.pa_rd) && can_cap && (bus.pa_wr || !tag_full);
      b_elig  = !rst && (bus.pb_wr || bus.pb_rd) && can_cap && (bus.pb_wr || !tag_full);
   end

   // Pick the winner: fixed priority to A, or alternate away from last_grant.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (a_elig && b_elig) begin
         if (FIXED_PRIORITY || last_grant == PORT_B) grant_a = 1'b1;
         else                                        grant_b = 1'b1;
      end else begin
         grant_a = a_elig;
         grant_b = b_elig;
      end
   end

   // Winner's command and tag bookkeeping strobes.
   always_comb begin
      win_id   = grant_b ? PORT_B : PORT_A;
      win_cmd  = grant_b ? b_cmd : a_cmd;
      capture  = grant_a || grant_b;
      tag_push = capture && !win_cmd.is_wr;
      tag_pop  = bus.val && !tag_empty;
   end

   // Command register: load on capture, otherwise drain once the controller accepts.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_valid  <= 1'b0;
         cmd_q      <= '0;
         last_grant <= PORT_B;
      end else if (capture) begin
         cmd_valid  <= 1'b1;
         cmd_q      <= win_cmd;
         last_grant <= win_id;
      end else if (bus.rdy) begin
         cmd_valid  <= 1'b0;
      end
   end

   // Route controller read data to the owning port; flag unsolicited responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         pa_rval_q  <= 1'b0;
         pb_rval_q  <= 1'b0;
         pa_rdata_q <= '0;
         pb_rdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         pa_rval_q <= tag_pop && (head_id == PORT_A);
         pb_rval_q <= tag_pop && (head_id == PORT_B);
         if (tag_pop && head_id == PORT_A) pa_rdata_q <= bus.data_rd;
         if (tag_pop && head_id == PORT_B) pb_rdata_q <= bus.data_rd;
         // Judged on pre-edge occupancy, so a same-cycle push does not cover it.
         if (bus.val && rd_count == '0) err_q <= 1'b1;
      end
   end

   assign bus.pa_ack   = grant_a;
   assign bus.pb_ack   = grant_b;
   assign bus.wr       = cmd_valid && cmd_q.is_wr;
   assign bus.rd       = cmd_valid && !cmd_q.is_wr;
   assign bus.addr_in  = cmd_q.addr;
   assign bus.data_wr  = cmd_q.wdata;
   assign bus.pa_rval  = pa_rval_q;
   assign bus.pb_rval  = pb_rval_q;
   assign bus.pa_rdata = pa_rdata_q;
   assign bus.pb_rdata = pb_rdata_q;
   assign bus.err_val  = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: one round-robin instance and one
// fixed-priority instance, with the controller side driven by hand.
module tb_sdram_port_arbiter;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   sdram_port_arbiter_if #(.ADDR_DEPTH(25)) if_rr ();
   sdram_port_arbiter_if #(.ADDR_DEPTH(25)) if_fp ();

   sdram_port_arbiter #(
      .ADDR_DEPTH         (25),
      .MAX_RD_OUTSTANDING (4),
      .FIXED_PRIORITY     (1'b0)
   ) u_rr (
      .clk (clk),
      .rst (rst),
      .bus (if_rr.slave)
   );

   sdram_port_arbiter #(
      .ADDR_DEPTH         (25),
      .MAX_RD_OUTSTANDING (4),
      .FIXED_PRIORITY     (1'b1)
   ) u_fp (
      .clk (clk),
      .rst (rst),
      .bus (if_fp.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are checked 1 ns later.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic pulse_rst();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      if_rr.pa_addr = '0; if_rr.pa_wdata = '0; if_rr.pa_wr = 1'b0; if_rr.pa_rd = 1'b0;
      if_rr.pb_addr = '0; if_rr.pb_wdata = '0; if_rr.pb_wr = 1'b0; if_rr.pb_rd = 1'b0;
      if_rr.rdy = 1'b1; if_rr.val = 1'b0; if_rr.data_rd = '0;
      if_fp.pa_addr = '0; if_fp.pa_wdata = '0; if_fp.pa_wr = 1'b0; if_fp.pa_rd = 1'b0;
      if_fp.pb_addr = '0; if_fp.pb_wdata = '0; if_fp.pb_wr = 1'b0; if_fp.pb_rd = 1'b0;
      if_fp.rdy = 1'b1; if_fp.val = 1'b0; if_fp.data_rd = '0;

      // ---- reset values
      cyc(); cyc(); #1;
      chk("rst_pa_ack", 32'(if_rr.pa_ack), 0);
      chk("rst_pb_ack", 32'(if_rr.pb_ack), 0);
      chk("rst_wr", 32'(if_rr.wr), 0);
      chk("rst_rd", 32'(if_rr.rd), 0);
      chk("rst_addr_in", 32'(if_rr.addr_in), 0);
      chk("rst_data_wr", 32'(if_rr.data_wr), 0);
      chk("rst_pa_rdata", 32'(if_rr.pa_rdata), 0);
      chk("rst_pb_rdata", 32'(if_rr.pb_rdata), 0);
      chk("rst_pa_rval", 32'(if_rr.pa_rval), 0);
      chk("rst_pb_rval", 32'(if_rr.pb_rval), 0);
      chk("rst_err_val", 32'(if_rr.err_val), 0);
      rst = 1'b0;

      // ---- single A read, val 4 clocks after rd
      cyc(); if_rr.pa_rd = 1'b1; if_rr.pa_addr = 25'h100; #1;
      chk("t1_ack_c0", 32'(if_rr.pa_ack), 1);
      chk("t1_rd_c0", 32'(if_rr.rd), 0);
      cyc(); if_rr.pa_rd = 1'b0; #1;
      chk("t1_ack_c1", 32'(if_rr.pa_ack), 0);
      chk("t1_rd_c1", 32'(if_rr.rd), 1);
      chk("t1_wr_c1", 32'(if_rr.wr), 0);
      chk("t1_addr_c1", 32'(if_rr.addr_in), 32'h100);
      cyc(); #1;
      chk("t1_rd_c2", 32'(if_rr.rd), 0);
      cyc(); cyc();
      cyc(); if_rr.val = 1'b1; if_rr.data_rd = 8'h5A;
      cyc(); if_rr.val = 1'b0; if_rr.data_rd = 8'h00; #1;
      chk("t1_pa_rval", 32'(if_rr.pa_rval), 1);
      chk("t1_pa_rdata", 32'(if_rr.pa_rdata), 32'h5A);
      chk("t1_pb_rval", 32'(if_rr.pb_rval), 0);
      cyc(); #1;
      chk("t1_pa_rval_end", 32'(if_rr.pa_rval), 0);
      chk("t1_pa_rdata_hold", 32'(if_rr.pa_rdata), 32'h5A);
      chk("t1_err", 32'(if_rr.err_val), 0);

      // ---- round-robin writes from both ports
      pulse_rst();
      cyc();
      if_rr.pa_wr = 1'b1; if_rr.pa_addr = 25'h0A0; if_rr.pa_wdata = 8'hC1;
      if_rr.pb_wr = 1'b1; if_rr.pb_addr = 25'h0B0; if_rr.pb_wdata = 8'hD2;
      #1;
      chk("rr_pa_ack_0", 32'(if_rr.pa_ack), 1);
      chk("rr_pb_ack_0", 32'(if_rr.pb_ack), 0);
      for (int i = 1; i <= 4; i++) begin
         cyc(); #1;
         chk("rr_pa_ack", 32'(if_rr.pa_ack), (i % 2 == 0) ? 1 : 0);
         chk("rr_pb_ack", 32'(if_rr.pb_ack), (i % 2 == 0) ? 0 : 1);
         chk("rr_wr", 32'(if_rr.wr), 1);
         chk("rr_addr", 32'(if_rr.addr_in), (i % 2 == 1) ? 32'h0A0 : 32'h0B0);
         chk("rr_data", 32'(if_rr.data_wr), (i % 2 == 1) ? 32'hC1 : 32'hD2);
      end
      cyc(); if_rr.pa_wr = 1'b0; if_rr.pb_wr = 1'b0; #1;
      chk("rr_idle_pa_ack", 32'(if_rr.pa_ack), 0);
      chk("rr_idle_pb_ack", 32'(if_rr.pb_ack), 0);
      chk("rr_last_wr", 32'(if_rr.wr), 1);
      chk("rr_last_addr", 32'(if_rr.addr_in), 32'h0A0);
      cyc(); #1;
      chk("rr_drained", 32'(if_rr.wr), 0);

      // ---- fixed priority: A always wins until it drops
      cyc();
      if_fp.pa_wr = 1'b1; if_fp.pa_addr = 25'h1A0; if_fp.pa_wdata = 8'h3C;
      if_fp.pb_wr = 1'b1; if_fp.pb_addr = 25'h1B0; if_fp.pb_wdata = 8'h4D;
      #1;
      chk("fp_pa_ack_0", 32'(if_fp.pa_ack), 1);
      chk("fp_pb_ack_0", 32'(if_fp.pb_ack), 0);
      for (int i = 1; i <= 2; i++) begin
         cyc(); #1;
         chk("fp_pa_ack", 32'(if_fp.pa_ack), 1);
         chk("fp_pb_ack", 32'(if_fp.pb_ack), 0);
      end
      cyc(); if_fp.pa_wr = 1'b0; #1;
      chk("fp_pa_ack_off", 32'(if_fp.pa_ack), 0);
      chk("fp_pb_ack_on", 32'(if_fp.pb_ack), 1);
      cyc(); if_fp.pb_wr = 1'b0; #1;
      chk("fp_b_wr", 32'(if_fp.wr), 1);
      chk("fp_b_addr", 32'(if_fp.addr_in), 32'h1B0);

      // ---- controller backpressure
      cyc(); if_rr.pa_wr = 1'b1; if_rr.pa_addr = 25'h033; if_rr.pa_wdata = 8'h77; #1;
      chk("bp_ack_0", 32'(if_rr.pa_ack), 1);
      cyc(); if_rr.pa_addr = 25'h044; if_rr.pa_wdata = 8'h88; if_rr.rdy = 1'b0; #1;
      chk("bp_ack_stall", 32'(if_rr.pa_ack), 0);
      chk("bp_wr_stall", 32'(if_rr.wr), 1);
      chk("bp_addr_stall", 32'(if_rr.addr_in), 32'h033);
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         chk("bp_wr_hold", 32'(if_rr.wr), 1);
         chk("bp_addr_hold", 32'(if_rr.addr_in), 32'h033);
         chk("bp_data_hold", 32'(if_rr.data_wr), 32'h77);
         chk("bp_ack_hold", 32'(if_rr.pa_ack), 0);
      end
      cyc(); if_rr.rdy = 1'b1; #1;
      chk("bp_ack_resume", 32'(if_rr.pa_ack), 1);
      chk("bp_addr_resume", 32'(if_rr.addr_in), 32'h033);
      cyc(); if_rr.pa_wr = 1'b0; #1;
      chk("bp_wr_next", 32'(if_rr.wr), 1);
      chk("bp_addr_next", 32'(if_rr.addr_in), 32'h044);
      chk("bp_data_next", 32'(if_rr.data_wr), 32'h88);
      cyc(); #1;
      chk("bp_drained", 32'(if_rr.wr), 0);

      // ---- fill the tag FIFO, stall a 5th read, route returns in order
      pulse_rst();
      cyc();
      if_rr.pa_rd = 1'b1; if_rr.pa_addr = 25'h200;
      if_rr.pb_rd = 1'b1; if_rr.pb_addr = 25'h300;
      #1;
      chk("ff_ack_a0", 32'(if_rr.pa_ack), 1);
      chk("ff_ack_b0", 32'(if_rr.pb_ack), 0);
      cyc(); #1;
      chk("ff_ack_b1", 32'(if_rr.pb_ack), 1);
      chk("ff_ack_a1", 32'(if_rr.pa_ack), 0);
      cyc(); #1;
      chk("ff_ack_a2", 32'(if_rr.pa_ack), 1);
      cyc(); #1;
      chk("ff_ack_b3", 32'(if_rr.pb_ack), 1);
      cyc(); if_rr.pb_rd = 1'b0; if_rr.pb_wr = 1'b1; if_rr.pb_wdata = 8'hE5; #1;
      chk("ff_full_rd_stall", 32'(if_rr.pa_ack), 0);
      chk("ff_full_wr_ack", 32'(if_rr.pb_ack), 1);
      cyc(); if_rr.pb_wr = 1'b0; if_rr.val = 1'b1; if_rr.data_rd = 8'h11; #1;
      chk("ff_pop_no_free", 32'(if_rr.pa_ack), 0);
      chk("ff_wr_issued", 32'(if_rr.wr), 1);
      cyc(); if_rr.data_rd = 8'h22; #1;
      chk("ff_ret1_rval", 32'(if_rr.pa_rval), 1);
      chk("ff_ret1_data", 32'(if_rr.pa_rdata), 32'h11);
      chk("ff_5th_ack", 32'(if_rr.pa_ack), 1);
      cyc(); if_rr.pa_rd = 1'b0; if_rr.data_rd = 8'h33; #1;
      chk("ff_ret2_rval", 32'(if_rr.pb_rval), 1);
      chk("ff_ret2_data", 32'(if_rr.pb_rdata), 32'h22);
      chk("ff_ret2_pa_quiet", 32'(if_rr.pa_rval), 0);
      cyc(); if_rr.data_rd = 8'h44; #1;
      chk("ff_ret3_rval", 32'(if_rr.pa_rval), 1);
      chk("ff_ret3_data", 32'(if_rr.pa_rdata), 32'h33);
      cyc(); if_rr.data_rd = 8'h55; #1;
      chk("ff_ret4_rval", 32'(if_rr.pb_rval), 1);
      chk("ff_ret4_data", 32'(if_rr.pb_rdata), 32'h44);
      cyc(); if_rr.val = 1'b0; if_rr.data_rd = 8'h00; #1;
      chk("ff_ret5_rval", 32'(if_rr.pa_rval), 1);
      chk("ff_ret5_data", 32'(if_rr.pa_rdata), 32'h55);
      chk("ff_ret5_pb_quiet", 32'(if_rr.pb_rval), 0);
      chk("ff_err_clear", 32'(if_rr.err_val), 0);

      // ---- unsolicited val sets sticky err_val
      cyc(); if_rr.val = 1'b1; if_rr.data_rd = 8'h99;
      cyc(); if_rr.val = 1'b0; if_rr.data_rd = 8'h00; #1;
      chk("err_set", 32'(if_rr.err_val), 1);
      chk("err_no_pa_rval", 32'(if_rr.pa_rval), 0);
      chk("err_no_pb_rval", 32'(if_rr.pb_rval), 0);
      chk("err_data_dropped", 32'(if_rr.pa_rdata), 32'h55);
      cyc(); #1;
      chk("err_sticky", 32'(if_rr.err_val), 1);

      // ---- reset with three reads outstanding
      cyc(); if_rr.pa_rd = 1'b1; if_rr.pa_addr = 25'h0C0; #1;
      chk("mr_ack0", 32'(if_rr.pa_ack), 1);
      cyc(); #1;
      chk("mr_ack1", 32'(if_rr.pa_ack), 1);
      cyc(); #1;
      chk("mr_ack2", 32'(if_rr.pa_ack), 1);
      cyc(); if_rr.pa_rd = 1'b0; rst = 1'b1; #1;
      chk("mr_rd_before", 32'(if_rr.rd), 1);
      cyc(); #1;
      chk("mr_err", 32'(if_rr.err_val), 0);
      chk("mr_rd", 32'(if_rr.rd), 0);
      chk("mr_wr", 32'(if_rr.wr), 0);
      chk("mr_addr", 32'(if_rr.addr_in), 0);
      chk("mr_data_wr", 32'(if_rr.data_wr), 0);
      chk("mr_pa_rdata", 32'(if_rr.pa_rdata), 0);
      chk("mr_pb_rdata", 32'(if_rr.pb_rdata), 0);
      chk("mr_pa_rval", 32'(if_rr.pa_rval), 0);
      chk("mr_pb_rval", 32'(if_rr.pb_rval), 0);
      chk("mr_pa_ack", 32'(if_rr.pa_ack), 0);
      rst = 1'b0;
      // Flushed FIFO: a stale val must count as unsolicited.
      cyc(); if_rr.val = 1'b1; if_rr.data_rd = 8'h66;
      cyc(); if_rr.val = 1'b0; if_rr.data_rd = 8'h00; #1;
      chk("mr_flushed_err", 32'(if_rr.err_val), 1);
      chk("mr_flushed_rval", 32'(if_rr.pa_rval), 0);

      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-port request arbiter placed directly upstream of the byte-wide SDRAM controller.
- Merges a high-bandwidth port (A, e.g. PPU) and a general port (B, e.g. CPU) onto the single controller command interface.
- Holds issued commands in a one-entry command register and tracks outstanding reads in order, so each controller val/data_rd pulse returns to the port that issued the read.

Parameters:
- ADDR_DEPTH, 25, address width, equal to the controller addr_in width.
- MAX_RD_OUTSTANDING, 4, depth of the read-tag FIFO; must be a power of 2 and ≥1.
- FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port A always wins.

Ports:
- clk  in  1  system clock, same clock as the controller.
- rst  in  1  synchronous, active-high reset.
- pa_addr  in  ADDR_DEPTH  port A byte address.
- pa_wdata  in  8  port A write data.
- pa_wr  in  1  port A write request (level; held until pa_ack).
- pa_rd  in  1  port A read request (level; held until pa_ack).
- pa_ack  out  1  port A request captured this cycle.
- pa_rdata  out  8  port A read data.
- pa_rval  out  1  port A read data valid, single-cycle pulse.
- pb_addr, pb_wdata, pb_wr, pb_rd, pb_ack, pb_rdata, pb_rval: identical to the port A set, for port B.
- addr_in  out  ADDR_DEPTH  controller address.
- data_wr  out  8  controller write data.
- wr  out  1  controller write command.
- rd  out  1  controller read command.
- rdy  in  1  controller can accept a command; a command is accepted when (wr|rd)&&rdy.
- val  in  1  controller read data valid; returns in issue order.
- data_rd  in  8  controller read data.
- err_val  out  1  sticky flag: val arrived while no read was outstanding.

Behaviour:
- Reset values (all outputs): ack, rval, wr, rd, err_val = 0; addr_in, data_wr, pa_rdata, pb_rdata = 0. The command register and tag FIFO are empty; last_grant = B, so A wins the first contention.
- Command register (cmd_valid, is_wr, addr, wdata) drives the controller: wr = cmd_valid&is_wr, rd = cmd_valid&!is_wr.
- A port is eligible when it has rd|wr asserted and can_cap is true.
  - can_cap = !cmd_valid || rdy.
  - For a read, the tag FIFO count must also be < MAX_RD_OUTSTANDING. A pop in the same cycle does not free a slot.
- Arbitration (combinational, same cycle):
  - Only one port eligible: that port wins.
  - Both eligible, FIXED_PRIORITY=1: A wins.
  - Both eligible, FIXED_PRIORITY=0: the port that is not last_grant wins.
- Capture:
  - The winner's ack is asserted combinationally for one cycle, and its request loads the command register at the clock edge.
  - last_grant updates to the winner.
  - A read pushes the winner's port id into the tag FIFO at capture.
- Issue: the command is visible to the controller the cycle after ack. cmd_valid clears when rdy is high, unless a new capture reloads it in the same cycle. Back-to-back issue every cycle is allowed while rdy stays high.
- rd and wr both high on one port: treated as a write; rd is ignored for that request.
- A port must hold addr/wdata/request stable until ack. It may deassert after ack, or keep the request high to issue another.
- Writes are never blocked by a full tag FIFO.
- Read return:
  - On val with FIFO non-empty: pop the head id and register data_rd into that port's rdata. Assert that port's rval for one cycle, 1 clk after val.
  - rdata holds its value until the next rval for that port.
- val with the FIFO empty: err_val is set (sticky until rst) and the data is discarded. A push in the same cycle does not satisfy it.
- Simultaneous push and pop: both take effect, count unchanged, order preserved.
- Pointer wrap: FIFO pointers wrap modulo MAX_RD_OUTSTANDING; the count is held in clog2(MAX_RD_OUTSTANDING)+1 bits.
- rst mid-operation: the command register and tag FIFO are flushed and in-flight reads are dropped. The controller shares rst, so no stale val is expected.

Decomposition:
- Package sdram_pkg:
  - typedef port_id_t (1-bit enum PORT_A=0, PORT_B=1);
  - struct sdram_cmd_t {is_wr, addr[ADDR_DEPTH-1:0], wdata[7:0]};
  - constant SDRAM_ADDR_DEPTH=25.
- Sub-module sdram_tag_fifo: synchronous FIFO of port_id_t, parameter DEPTH, with push/pop/full/empty/count. It is also reused later for a multi-port version.

Test Plan:
- Single A read, rdy=1, controller val 4 clks after rd, data_rd=0x5A -> pa_ack at cycle 0, rd at cycle 1, pa_rval with pa_rdata=0x5A 1 clk after val, pb_rval stays 0.
- A and B both request writes continuously, FIXED_PRIORITY=0, rdy=1 -> acks alternate A,B,A,B starting with A, one command per cycle.
- Same stimulus with FIXED_PRIORITY=1 -> only pa_ack pulses until A deasserts, then B is granted the next cycle.
- rdy held low 5 cycles with a command pending -> wr/rd and addr_in stay stable, no further acks, and the pending request is captured in the cycle rdy returns.
- Issue reads A,B,A,B (FIFO full at 4); a 5th read is stalled and a concurrent write is still acked; vals return 0x11,0x22,0x33,0x44 -> routed A,B,A,B in order, then the 5th read is acked after the first val.
- val pulse with nothing outstanding -> err_val=1 and stays 1 until rst; rst mid-burst with 3 reads outstanding -> FIFO empty, all outputs at reset values the next cycle.
